// File: rtl/m_mem_port.sv
// MEM-stage load/store unit: decodes the EX/MEM instruction, runs a req/ack transaction with
// timeout while holding the pipeline, and returns extended load data plus error pulses.
module m_mem_port #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_m,
  input  logic [31:0] pc_m,
  input  logic [31:0] addr_m,
  input  logic [31:0] wdata_m,
  output logic        stall_m,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        addr_err,
  output logic        timeout_err,
  output logic [31:0] err_pc
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [1:0] SzByte = 2'd0;
  localparam logic [1:0] SzHalf = 2'd1;
  localparam logic [1:0] SzWord = 2'd2;
  localparam logic [7:0] LastCnt = 8'(MAX_WAIT - 1);

  state_t      state;
  logic        isLoad, isStore, isMem, accSigned, aligned;
  logic [1:0]  accSize;
  logic [3:0]  beNext;
  logic [31:0] wdataNext;

  logic        opLoad, opSigned;
  logic [1:0]  opSize, opLane;
  logic [31:0] opPc;
  logic [7:0]  waitCnt;
  logic [31:0] laneWord, loadExt;

  // Only the opcode field matters here; the rest of the instruction is intentionally ignored.
  logic unusedInstr;
  assign unusedInstr = ^instr_m[25:0];

  always_comb begin
    isLoad    = 1'b0;
    isStore   = 1'b0;
    accSize   = SzByte;
    accSigned = 1'b0;
    case (instr_m[31:26])
      6'b100011: begin isLoad = 1'b1;  accSize = SzWord; end
      6'b100001: begin isLoad = 1'b1;  accSize = SzHalf; accSigned = 1'b1; end
      6'b100101: begin isLoad = 1'b1;  accSize = SzHalf; end
      6'b100000: begin isLoad = 1'b1;  accSize = SzByte; accSigned = 1'b1; end
      6'b100100: begin isLoad = 1'b1;  accSize = SzByte; end
      6'b101011: begin isStore = 1'b1; accSize = SzWord; end
      6'b101001: begin isStore = 1'b1; accSize = SzHalf; end
      6'b101000: begin isStore = 1'b1; accSize = SzByte; end
      default: ;
    endcase
  end

  always_comb begin
    aligned   = 1'b1;
    beNext    = 4'b0001 << addr_m[1:0];
    wdataNext = {4{wdata_m[7:0]}};
    case (accSize)
      SzWord: begin
        aligned   = (addr_m[1:0] == 2'b00);
        beNext    = 4'b1111;
        wdataNext = wdata_m;
      end
      SzHalf: begin
        aligned   = ~addr_m[0];
        beNext    = addr_m[1] ? 4'b1100 : 4'b0011;
        wdataNext = {2{wdata_m[15:0]}};
      end
      default: ;
    endcase
  end

  assign isMem    = isLoad | isStore;
  // DONE never re-decodes instr_m, so the completed instruction cannot issue twice.
  assign stall_m  = (state == WAIT) || ((state == IDLE) && isMem && aligned);
  assign addr_err = (state == IDLE) && isMem && !aligned;

  assign laneWord = mem_rdata >> {opLane, 3'b000};
  always_comb begin
    loadExt = mem_rdata;
    case (opSize)
      SzByte:  loadExt = {{24{opSigned & laneWord[7]}}, laneWord[7:0]};
      SzHalf:  loadExt = {{16{opSigned & laneWord[15]}}, laneWord[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_be      <= '0;
      mem_wdata   <= '0;
      load_data   <= '0;
      load_valid  <= 1'b0;
      timeout_err <= 1'b0;
      err_pc      <= '0;
      opLoad      <= 1'b0;
      opSigned    <= 1'b0;
      opSize      <= SzByte;
      opLane      <= 2'b00;
      opPc        <= '0;
      waitCnt     <= '0;
    end else begin
      load_valid  <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (addr_err) begin
            err_pc <= pc_m;
          end else if (isMem) begin
            state     <= WAIT;
            mem_req   <= 1'b1;
            mem_we    <= isStore;
            mem_addr  <= {addr_m[31:2], 2'b00};
            mem_be    <= beNext;
            mem_wdata <= wdataNext;
            opLoad    <= isLoad;
            opSigned  <= accSigned;
            opSize    <= accSize;
            opLane    <= addr_m[1:0];
            opPc      <= pc_m;
            waitCnt   <= '0;
          end
        end
        WAIT: begin
          // An ack on the final permitted cycle still completes the access.
          if (mem_ack) begin
            state   <= DONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_be  <= '0;
            if (opLoad) begin
              load_data  <= loadExt;
              load_valid <= 1'b1;
            end
          end else if (waitCnt == LastCnt) begin
            state       <= DONE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_be      <= '0;
            load_data   <= '0;
            timeout_err <= 1'b1;
            err_pc      <= opPc;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
